motion_safety_arbiter: RTL and testbench

//  Turns Arduino command bytes into a rate-limited {move_cmd, speed_level} stream for the UART transmitter.

---
 rtl/motion_safety_arbiter.sv | 255 +++++++++++++++++++++++++
 tb/tb_motion_safety_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/motion_safety_arbiter.sv
// Motion safety arbiter: decodes command bytes, gates motion by front/rear proximity,
// ramps speed, runs a command watchdog and emits {move, speed} frames over valid/ready.
// Optional build macro PROX_HYST_EN adds +5 hysteresis to the stop and slow thresholds.
module motion_safety_arbiter #(
    parameter int N_SENSORS      = 2,
    parameter int N_FRONT        = 1,
    parameter int DIST_W         = 8,
    parameter int STOP_DIST      = 15,
    parameter int SLOW_DIST      = 40,
    parameter int SLOW_SPEED     = 2,
    parameter int RAMP_CYCLES    = 2_500_000,
    parameter int TIMEOUT_CYCLES = 25_000_000,
    parameter int REFRESH_CYCLES = 5_000_000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  cmd_byte,
    input  logic                        cmd_valid,
    input  logic [N_SENSORS*DIST_W-1:0] dist_in,
    input  logic [N_SENSORS-1:0]        dist_valid,
    output logic [3:0]                  move_cmd,
    output logic [3:0]                  speed_level,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        servo,
    output logic                        blocked,
    output logic                        timeout,
    output logic [1:0]                  motion_state,
    output logic                        tx_state
);

    // Output handshake: a frame {move_cmd, speed_level} is offered while out_valid=1 and
    // is held stable until the cycle where out_valid && out_ready; that cycle consumes it.

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_BLOCK = 2'd1;
    localparam logic [1:0] ST_TMO   = 2'd2;

    localparam logic [0:0] TX_IDLE  = 1'b0;
    localparam logic [0:0] TX_SEND  = 1'b1;

    localparam logic [3:0] MV_STOP  = 4'd8;

    localparam int WD_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RAMP_W = $clog2(RAMP_CYCLES + 1);
    localparam int REF_W  = $clog2(REFRESH_CYCLES + 1);

    localparam logic [WD_W-1:0]   WD_MAX    = WD_W'(TIMEOUT_CYCLES);
    localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_CYCLES - 1);
    localparam logic [REF_W-1:0]  REF_LAST  = REF_W'(REFRESH_CYCLES - 1);

    localparam logic [DIST_W:0] STOP_SET = (DIST_W+1)'(STOP_DIST);
    localparam logic [DIST_W:0] SLOW_SET = (DIST_W+1)'(SLOW_DIST);
`ifdef PROX_HYST_EN
    localparam logic [DIST_W:0] STOP_CLR = (DIST_W+1)'(STOP_DIST + 5);
    localparam logic [DIST_W:0] SLOW_CLR = (DIST_W+1)'(SLOW_DIST + 5);
`else
    localparam logic [DIST_W:0] STOP_CLR = (DIST_W+1)'(STOP_DIST);
    localparam logic [DIST_W:0] SLOW_CLR = (DIST_W+1)'(SLOW_DIST);
`endif

    logic [DIST_W-1:0] dist_q [N_SENSORS];
    logic [DIST_W-1:0] dist_d [N_SENSORS];
    logic [DIST_W-1:0] front_min;
    logic [DIST_W-1:0] rear_min;

    logic [3:0]        tgt_move_q, tgt_move_d;
    logic [3:0]        tgt_speed_q, tgt_speed_d;
    logic              front_blk_q, front_blk_d;
    logic              rear_blk_q, rear_blk_d;
    logic              front_slow_q, front_slow_d;
    logic              rear_slow_q, rear_slow_d;
    logic [WD_W-1:0]   wd_cnt, wd_d;
    logic [1:0]        state_q, state_d;
    logic [3:0]        eff_move_q, eff_d;
    logic [3:0]        speed_q, speed_d;
    logic [RAMP_W-1:0] ramp_cnt, ramp_d;
    logic [3:0]        cap;
    logic [3:0]        goal;
    logic              is_move;
    logic              is_speed;
    logic              move_blocked;
    logic              cap_slow;

    logic [0:0]        tx_q;
    logic [3:0]        last_move;
    logic [3:0]        last_speed;
    logic [REF_W-1:0]  refresh_cnt;
    logic              frame_diff;

    assign is_move  = cmd_valid && (cmd_byte[7:4] == 4'h1) && (cmd_byte[3:0] <= 4'd8);
    assign is_speed = cmd_valid && (cmd_byte[7:4] == 4'h2);

    assign tgt_move_d  = is_move  ? cmd_byte[3:0] : tgt_move_q;
    assign tgt_speed_d = is_speed ? cmd_byte[3:0] : tgt_speed_q;

    // Group minima are taken over this cycle's incoming distances so a strobe acts at once.
    always_comb begin
        front_min = '1;
        rear_min  = '1;
        for (int i = 0; i < N_SENSORS; i++) begin
            dist_d[i] = dist_valid[i] ? dist_in[i*DIST_W +: DIST_W] : dist_q[i];
            if (i < N_FRONT) begin
                if (dist_d[i] < front_min) front_min = dist_d[i];
            end else begin
                if (dist_d[i] < rear_min) rear_min = dist_d[i];
            end
        end
    end

    assign front_blk_d  = front_blk_q  ? ({1'b0, front_min} <= STOP_CLR) : ({1'b0, front_min} <= STOP_SET);
    assign rear_blk_d   = rear_blk_q   ? ({1'b0, rear_min}  <= STOP_CLR) : ({1'b0, rear_min}  <= STOP_SET);
    assign front_slow_d = front_slow_q ? ({1'b0, front_min} <  SLOW_CLR) : ({1'b0, front_min} <  SLOW_SET);
    assign rear_slow_d  = rear_slow_q  ? ({1'b0, rear_min}  <  SLOW_CLR) : ({1'b0, rear_min}  <  SLOW_SET);

    always_comb begin
        move_blocked = 1'b0;
        case (tgt_move_d)
            4'd0, 4'd1, 4'd2: move_blocked = front_blk_d;
            4'd3, 4'd6, 4'd7: move_blocked = rear_blk_d;
            default:          move_blocked = 1'b0;
        endcase
    end

    assign wd_d = is_move ? '0 : ((wd_cnt == WD_MAX) ? wd_cnt : wd_cnt + WD_W'(1));

    // A move byte outranks a simultaneous watchdog expiry.
    always_comb begin
        state_d = state_q;
        if (is_move) begin
            state_d = move_blocked ? ST_BLOCK : ST_RUN;
        end else if (wd_d == WD_MAX) begin
            state_d = ST_TMO;
        end else if (state_q == ST_TMO) begin
            state_d = ST_TMO;
        end else begin
            state_d = move_blocked ? ST_BLOCK : ST_RUN;
        end
    end

    assign eff_d = (state_d == ST_RUN) ? tgt_move_d : MV_STOP;

    // Spins have no single facing side, so either group being near caps them.
    always_comb begin
        cap_slow = front_slow_d || rear_slow_d;
        case (eff_d)
            4'd0, 4'd1, 4'd2: cap_slow = front_slow_d;
            4'd3, 4'd6, 4'd7: cap_slow = rear_slow_d;
            default:          cap_slow = front_slow_d || rear_slow_d;
        endcase
        cap  = cap_slow ? 4'(SLOW_SPEED) : 4'd15;
        goal = (tgt_speed_d < cap) ? tgt_speed_d : cap;
    end

    // Stopping zeroes speed and restarts the ramp interval so acceleration begins cleanly.
    always_comb begin
        ramp_d  = ramp_cnt;
        speed_d = speed_q;
        if (eff_d == MV_STOP) begin
            ramp_d  = '0;
            speed_d = 4'd0;
        end else if (ramp_cnt == RAMP_LAST) begin
            ramp_d = '0;
            if (speed_q < goal) begin
                speed_d = speed_q + 4'd1;
            end else if (speed_q > goal) begin
                speed_d = speed_q - 4'd1;
            end
        end else begin
            ramp_d = ramp_cnt + RAMP_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_SENSORS; i++) begin
                dist_q[i] <= '0;
            end
            tgt_move_q   <= MV_STOP;
            tgt_speed_q  <= 4'd0;
            front_blk_q  <= 1'b1;
            rear_blk_q   <= 1'b1;
            front_slow_q <= 1'b1;
            rear_slow_q  <= 1'b1;
            wd_cnt       <= WD_MAX;
            state_q      <= ST_TMO;
            eff_move_q   <= MV_STOP;
            speed_q      <= 4'd0;
            ramp_cnt     <= '0;
            servo        <= 1'b0;
        end else begin
            for (int i = 0; i < N_SENSORS; i++) begin
                dist_q[i] <= dist_d[i];
            end
            tgt_move_q   <= tgt_move_d;
            tgt_speed_q  <= tgt_speed_d;
            front_blk_q  <= front_blk_d;
            rear_blk_q   <= rear_blk_d;
            front_slow_q <= front_slow_d;
            rear_slow_q  <= rear_slow_d;
            wd_cnt       <= wd_d;
            state_q      <= state_d;
            eff_move_q   <= eff_d;
            speed_q      <= speed_d;
            ramp_cnt     <= ramp_d;
            if (cmd_valid && (cmd_byte == 8'hF0)) begin
                servo <= 1'b1;
            end else if (cmd_valid && (cmd_byte == 8'hC0)) begin
                servo <= 1'b0;
            end
        end
    end

    assign blocked      = (state_q == ST_BLOCK);
    assign timeout      = (state_q == ST_TMO);
    assign motion_state = state_q;

    assign frame_diff = (eff_move_q != last_move) || (speed_q != last_speed);

    // The payload is captured on entry to SEND; later changes wait in eff_move_q/speed_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_q        <= TX_IDLE;
            move_cmd    <= MV_STOP;
            speed_level <= 4'd0;
            last_move   <= MV_STOP;
            last_speed  <= 4'd0;
            refresh_cnt <= '0;
        end else begin
            case (tx_q)
                TX_IDLE: begin
                    if (frame_diff || (refresh_cnt == REF_LAST)) begin
                        move_cmd    <= eff_move_q;
                        speed_level <= speed_q;
                        refresh_cnt <= '0;
                        tx_q        <= TX_SEND;
                    end else begin
                        refresh_cnt <= refresh_cnt + REF_W'(1);
                    end
                end
                default: begin
                    if (out_ready) begin
                        last_move  <= move_cmd;
                        last_speed <= speed_level;
                        tx_q       <= TX_IDLE;
                    end
                end
            endcase
        end
    end

    assign out_valid = (tx_q == TX_SEND);
    assign tx_state  = tx_q;

endmodule

// File: tb/tb_motion_safety_arbiter.sv
// Directed bench for motion_safety_arbiter with short ramp/watchdog intervals.
// Covers ramping, proximity blocking, slow caps, watchdog, frozen payload, servo and hysteresis.
module tb_motion_safety_arbiter;

    localparam int RAMP = 4;
    localparam int TMO  = 300;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  cmd_byte = 8'h00;
    logic        cmd_valid = 1'b0;
    logic [15:0] dist_in = 16'h0000;
    logic [1:0]  dist_valid = 2'b00;
    logic [3:0]  move_cmd;
    logic [3:0]  speed_level;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        servo;
    logic        blocked;
    logic        timeout;
    logic [1:0]  motion_state;
    logic        tx_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int frame_cyc = 0;
    int byte_cyc = 0;
    int prev_cyc = 0;

    motion_safety_arbiter #(
        .N_SENSORS(2), .N_FRONT(1), .DIST_W(8), .STOP_DIST(15), .SLOW_DIST(40),
        .SLOW_SPEED(2), .RAMP_CYCLES(RAMP), .TIMEOUT_CYCLES(TMO), .REFRESH_CYCLES(100000)
    ) dut (
        .clk(clk), .rst(rst), .cmd_byte(cmd_byte), .cmd_valid(cmd_valid),
        .dist_in(dist_in), .dist_valid(dist_valid), .move_cmd(move_cmd),
        .speed_level(speed_level), .out_valid(out_valid), .out_ready(out_ready),
        .servo(servo), .blocked(blocked), .timeout(timeout),
        .motion_state(motion_state), .tx_state(tx_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit observed=expired expected=finish");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_cyc  = cyc;
        cmd_byte  = b;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic set_dist(input int ch, input logic [7:0] v);
        dist_in[ch*8 +: 8] = v;
        dist_valid = 2'(1 << ch);
        @(negedge clk);
        dist_valid = 2'b00;
    endtask

    // Waits (bounded) for an offered frame, checks it, and steps past its handshake.
    task automatic get_frame(input string tag, input logic [3:0] em, input logic [3:0] es, input int max_cyc);
        int n = 0;
        while (out_valid !== 1'b1 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (out_valid === 1'b1) else begin
            errors++;
            $error("FAIL %s_wait observed=no_frame expected=frame_within_%0d", tag, max_cyc);
        end
        if (out_valid === 1'b1) begin
            check({tag, "_move"}, 32'(move_cmd), 32'(em));
            check({tag, "_speed"}, 32'(speed_level), 32'(es));
            frame_cyc = cyc;
            @(negedge clk);
        end
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_move", 32'(move_cmd), 32'd8);
        check("rst_speed", 32'(speed_level), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_servo", 32'(servo), 32'd0);
        check("rst_blocked", 32'(blocked), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // 1: distances and target speed in one cycle, then forward; ramp 0..15
        cmd_byte = 8'h2F; cmd_valid = 1'b1;
        dist_in = {8'd100, 8'd100}; dist_valid = 2'b11;
        @(negedge clk);
        cmd_valid = 1'b0; dist_valid = 2'b00;
        send_byte(8'h10);
        check("lat_n1_valid", 32'(out_valid), 32'd0);
        check("lat_n1_timeout", 32'(timeout), 32'd0);
        @(negedge clk);
        check("lat_n2_valid", 32'(out_valid), 32'd1);
        get_frame("fwd_start", 4'd0, 4'd0, 2);
        for (int s = 1; s <= 15; s++) begin
            get_frame("ramp", 4'd0, 4'(s), 20);
            if (s >= 2) check("ramp_step_cycles", 32'(frame_cyc - prev_cyc), 32'(RAMP));
            prev_cyc = frame_cyc;
        end

        // 2: front obstacle stops forward; spin is allowed but capped near obstacle
        set_dist(0, 8'd10);
        check("front_blocked_now", 32'(blocked), 32'd1);
        get_frame("front_stop", 4'd8, 4'd0, 10);
        send_byte(8'h14);
        check("spin_unblocked", 32'(blocked), 32'd0);
        get_frame("spin_start", 4'd4, 4'd0, 10);
        get_frame("spin_r1", 4'd4, 4'd1, 20);
        get_frame("spin_r2", 4'd4, 4'd2, 20);

        // 3: reverse with rear slow cap, rear stop, front-only obstacle ignored
        send_byte(8'h18);
        get_frame("stop_byte", 4'd8, 4'd0, 10);
        set_dist(1, 8'd30);
        send_byte(8'h28);
        send_byte(8'h13);
        get_frame("rev_start", 4'd3, 4'd0, 10);
        get_frame("rev_r1", 4'd3, 4'd1, 20);
        get_frame("rev_r2", 4'd3, 4'd2, 20);
        repeat (20) @(negedge clk);
        check("rev_cap_no_frame", 32'(out_valid), 32'd0);
        check("rev_cap_speed", 32'(speed_level), 32'd2);
        set_dist(1, 8'd12);
        get_frame("rear_stop", 4'd8, 4'd0, 10);
        check("rear_blocked", 32'(blocked), 32'd1);
        set_dist(1, 8'd100);
        get_frame("rear_clear", 4'd3, 4'd0, 10);
        check("rear_unblocked", 32'(blocked), 32'd0);
        set_dist(0, 8'd5);
        get_frame("rev_front_near", 4'd3, 4'd1, 20);
        check("rev_front_not_blocked", 32'(blocked), 32'd0);
        for (int s = 2; s <= 8; s++) begin
            get_frame("rev_ramp", 4'd3, 4'(s), 20);
        end

        // 4: watchdog expiry forces stop; move byte restarts ramp from 0
        get_frame("wd_stop", 4'd8, 4'd0, 400);
        check("wd_cycles", 32'(frame_cyc - byte_cyc), 32'(TMO + 2));
        check("wd_timeout", 32'(timeout), 32'd1);
        set_dist(0, 8'd100);
        check("wd_hold_no_frame", 32'(out_valid), 32'd0);
        send_byte(8'h10);
        check("wd_cleared", 32'(timeout), 32'd0);
        get_frame("wd_resume", 4'd0, 4'd0, 10);
        for (int s = 1; s <= 8; s++) begin
            get_frame("wd_ramp", 4'd0, 4'(s), 20);
        end

        // 5: payload frozen while out_ready is low
        out_ready = 1'b0;
        send_byte(8'h14);
        repeat (3) @(negedge clk);
        check("frz_valid", 32'(out_valid), 32'd1);
        check("frz_move_a", 32'(move_cmd), 32'd4);
        check("frz_speed_a", 32'(speed_level), 32'd8);
        send_byte(8'h15);
        repeat (3) @(negedge clk);
        check("frz_move_b", 32'(move_cmd), 32'd4);
        send_byte(8'h18);
        repeat (3) @(negedge clk);
        check("frz_move_c", 32'(move_cmd), 32'd4);
        check("frz_speed_c", 32'(speed_level), 32'd8);
        out_ready = 1'b1;
        get_frame("frz_release", 4'd4, 4'd8, 2);
        get_frame("frz_latest", 4'd8, 4'd0, 10);

        // 6: servo bytes, ignored move byte, proximity thresholds
        send_byte(8'hF0);
        check("servo_on", 32'(servo), 32'd1);
        send_byte(8'hC0);
        check("servo_off", 32'(servo), 32'd0);
        send_byte(8'h19);
        repeat (10) @(negedge clk);
        check("bad_move_no_frame", 32'(out_valid), 32'd0);
        check("bad_move_cmd", 32'(move_cmd), 32'd8);
        send_byte(8'h20);
        send_byte(8'h10);
        get_frame("hy_fwd", 4'd0, 4'd0, 10);
        set_dist(0, 8'd10);
        get_frame("hy_block", 4'd8, 4'd0, 10);
        check("hy_blocked_10", 32'(blocked), 32'd1);
        set_dist(0, 8'd18);
`ifdef PROX_HYST_EN
        repeat (5) @(negedge clk);
        check("hy_blocked_18", 32'(blocked), 32'd1);
        check("hy_no_frame_18", 32'(out_valid), 32'd0);
        set_dist(0, 8'd21);
        get_frame("hy_clear_21", 4'd0, 4'd0, 10);
        check("hy_blocked_21", 32'(blocked), 32'd0);
`else
        get_frame("hy_clear_18", 4'd0, 4'd0, 10);
        check("hy_blocked_18", 32'(blocked), 32'd0);
        set_dist(0, 8'd21);
        repeat (5) @(negedge clk);
        check("hy_blocked_21", 32'(blocked), 32'd0);
`endif
        set_dist(0, 8'd15);
        get_frame("edge_block_15", 4'd8, 4'd0, 10);
        check("edge_blocked_15", 32'(blocked), 32'd1);
        set_dist(0, 8'd16);
`ifdef PROX_HYST_EN
        repeat (5) @(negedge clk);
        check("edge_blocked_16", 32'(blocked), 32'd1);
`else
        get_frame("edge_clear_16", 4'd0, 4'd0, 10);
        check("edge_blocked_16", 32'(blocked), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
